// File: rtl/eth_frame_pkg.sv
// Shared types and width helpers for the frame-detector match logger.
// A log entry is {timestamp, iface_idx, pattern_mask, ext_num}, MSB first.
package eth_frame_pkg;

    localparam int C_EXT_NUM_W     = 5;
    localparam int C_TS_W          = 64;
    localparam int C_MAX_IDX_W     = 3;
    localparam int C_MAX_PATTERNS  = 8;

    // Widest entry layout (8 channels, 8 patterns); narrower builds pack the
    // same fields at their configured widths.
    typedef struct packed {
        logic [C_TS_W-1:0]         timestamp;
        logic [C_MAX_IDX_W-1:0]    iface_idx;
        logic [C_MAX_PATTERNS-1:0] pattern_mask;
        logic [C_EXT_NUM_W-1:0]    ext_num;
    } log_entry_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int log_width(input int n, input int p);
        return C_TS_W + idx_width(n) + p + C_EXT_NUM_W;
    endfunction

endpackage

// File: rtl/eth_frame_log_fifo.sv
// First-word-fall-through log FIFO: synchronous-read memory plus a head
// register, with a write bypass so a write into an empty FIFO is visible next cycle.
module eth_frame_log_fifo #(
    parameter  int C_WIDTH = 74,
    parameter  int C_DEPTH = 512,
    localparam int AW      = $clog2(C_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               srst,
    input  logic               wr_en_i,
    input  logic [C_WIDTH-1:0] wr_data_i,
    output logic               full_o,
    input  logic               rd_en_i,
    output logic [C_WIDTH-1:0] rd_data_o,
    output logic               rd_valid_o,
    output logic [AW:0]        occupancy_o
);

    logic [C_WIDTH-1:0] mem_q [C_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW-1:0]      rd_ptr_d;
    logic [AW:0]        count_q;
    logic [AW:0]        count_d;
    logic [C_WIDTH-1:0] head_q;
    logic               push;
    logic               pop;

    assign full_o      = (count_q == (AW+1)'(C_DEPTH));
    assign rd_valid_o  = (count_q != '0);
    assign rd_data_o   = head_q;
    assign occupancy_o = count_q;
    assign push        = wr_en_i && !full_o;
    assign pop         = rd_en_i && rd_valid_o;
    assign rd_ptr_d    = rd_ptr_q + AW'(pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // The next head is either the word being written right now or one already in memory.
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_q <= wr_data_i;
            end else if (count_d != '0) begin
                head_q <= mem_q[rd_ptr_d];
            end
        end
    end

endmodule

// File: rtl/eth_frame_match_log.sv
// N-channel match-event logger: per-channel timestamped hold registers merged
// round-robin into one log FIFO that drains as a valid/ready stream.
module eth_frame_match_log
    import eth_frame_pkg::*;
#(
    parameter  int C_NUM_IFACES   = 2,
    parameter  int C_NUM_PATTERNS = 4,
    parameter  int C_FIFO_DEPTH   = 512,
    localparam int LOG_W          = log_width(C_NUM_IFACES, C_NUM_PATTERNS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   srst,
    input  logic [C_NUM_IFACES-1:0]                log_en,
    input  logic [C_TS_W-1:0]                      current_time,
    input  logic                                   time_running,
    input  logic [C_NUM_IFACES*C_NUM_PATTERNS-1:0] match,
    input  logic [C_NUM_IFACES*C_EXT_NUM_W-1:0]    match_ext_num,
    output logic [LOG_W-1:0]                       m_log_tdata,
    output logic                                   m_log_tvalid,
    input  logic                                   m_log_tready,
    output logic [$clog2(C_FIFO_DEPTH):0]          occupancy,
    output logic [31:0]                            drop_count
);

    localparam int N     = C_NUM_IFACES;
    localparam int P     = C_NUM_PATTERNS;
    localparam int IDX_W = idx_width(C_NUM_IFACES);

    logic [C_TS_W-1:0]      hold_ts_q   [N];
    logic [P-1:0]           hold_mask_q [N];
    logic [C_EXT_NUM_W-1:0] hold_ext_q  [N];
    logic [N-1:0]           hold_valid_q;
    logic [IDX_W-1:0]       rr_q;
    logic [IDX_W-1:0]       rr_d;
    logic [31:0]            drop_count_q;
    logic [31:0]            drop_count_d;

    logic [N-1:0]           event_c;
    logic [N-1:0]           grant_oh;
    logic [N-1:0]           drop_c;
    logic                   grant_any;
    logic [IDX_W-1:0]       grant_idx;
    logic                   fifo_full;
    logic [LOG_W-1:0]       fifo_wdata;
    logic [3:0]             ndrop;
    logic [32:0]            drop_total;

    always_comb begin
        for (int c = 0; c < N; c++) begin
            event_c[c] = time_running && log_en[c] && (|match[c*P +: P]);
        end
    end

    // Round-robin search starting at rr_q; nothing is granted while the FIFO is full.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] cidx;
        pos       = 0;
        cidx      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(rr_q) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            cidx = IDX_W'(pos);
            if (!grant_any && !fifo_full && hold_valid_q[cidx]) begin
                grant_any      = 1'b1;
                grant_idx      = cidx;
                grant_oh[cidx] = 1'b1;
            end
        end
    end

    always_comb begin
        ndrop = '0;
        for (int c = 0; c < N; c++) begin
            drop_c[c] = event_c[c] && hold_valid_q[c] && !grant_oh[c];
            ndrop     = ndrop + 4'(drop_c[c]);
        end
        drop_total   = {1'b0, drop_count_q} + 33'(ndrop);
        drop_count_d = drop_total[32] ? 32'hFFFF_FFFF : drop_total[31:0];
        rr_d         = rr_q;
        if (grant_any) begin
            rr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign fifo_wdata = {hold_ts_q[grant_idx], grant_idx, hold_mask_q[grant_idx], hold_ext_q[grant_idx]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= '0;
            rr_q         <= '0;
            drop_count_q <= '0;
        end else if (srst) begin
            hold_valid_q <= '0;
            rr_q         <= '0;
            drop_count_q <= '0;
        end else begin
            rr_q         <= rr_d;
            drop_count_q <= drop_count_d;
            // A hold being drained this cycle can take a new event at the same edge.
            for (int c = 0; c < N; c++) begin
                if (event_c[c] && (!hold_valid_q[c] || grant_oh[c])) begin
                    hold_valid_q[c] <= 1'b1;
                end else if (grant_oh[c]) begin
                    hold_valid_q[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (event_c[c] && (!hold_valid_q[c] || grant_oh[c])) begin
                hold_ts_q[c]   <= current_time;
                hold_mask_q[c] <= match[c*P +: P];
                hold_ext_q[c]  <= match_ext_num[c*C_EXT_NUM_W +: C_EXT_NUM_W];
            end
        end
    end

    assign drop_count = drop_count_q;

    eth_frame_log_fifo #(
        .C_WIDTH (LOG_W),
        .C_DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .srst        (srst),
        .wr_en_i     (grant_any),
        .wr_data_i   (fifo_wdata),
        .full_o      (fifo_full),
        .rd_en_i     (m_log_tready),
        .rd_data_o   (m_log_tdata),
        .rd_valid_o  (m_log_tvalid),
        .occupancy_o (occupancy)
    );

endmodule

// File: tb/tb_eth_frame_match_log.sv
// Bench for eth_frame_match_log (2 channels, 4 patterns, 4-deep FIFO) against
// a queue-level reference model of holds, round-robin merge and the log FIFO.
module tb_eth_frame_match_log;

    localparam int N     = 2;
    localparam int P     = 4;
    localparam int D     = 4;
    localparam int IDX_W = 1;
    localparam int LOG_W = 64 + IDX_W + P + 5;
    localparam int OCC_W = $clog2(D) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             srst = 1'b0;
    logic [N-1:0]     log_en;
    logic [63:0]      current_time;
    logic             time_running;
    logic [N*P-1:0]   match;
    logic [N*5-1:0]   match_ext_num;
    logic [LOG_W-1:0] m_log_tdata;
    logic             m_log_tvalid;
    logic             m_log_tready;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      drop_count;

    int errors = 0;
    int checks = 0;

    logic [LOG_W-1:0] exp_q[$];
    bit               m_hv [N];
    logic [LOG_W-1:0] m_hd [N];
    int               m_rr;
    logic [31:0]      m_drop;

    eth_frame_match_log #(
        .C_NUM_IFACES   (N),
        .C_NUM_PATTERNS (P),
        .C_FIFO_DEPTH   (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .srst          (srst),
        .log_en        (log_en),
        .current_time  (current_time),
        .time_running  (time_running),
        .match         (match),
        .match_ext_num (match_ext_num),
        .m_log_tdata   (m_log_tdata),
        .m_log_tvalid  (m_log_tvalid),
        .m_log_tready  (m_log_tready),
        .occupancy     (occupancy),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [LOG_W-1:0] mk_entry(input logic [63:0] ts, input int ch,
                                                  input logic [P-1:0] mask, input logic [4:0] ext);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(ch);
        return {ts, idx, mask, ext};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int c = 0; c < N; c++) begin
            m_hv[c] = 1'b0;
            m_hd[c] = '0;
        end
        m_rr   = 0;
        m_drop = '0;
    endtask

    // One clock edge of the logger, from the rules: pop, merge one hold, capture/drop.
    task automatic model_step();
        int g;
        bit found;
        if (srst) begin
            model_reset();
            return;
        end
        found = 1'b0;
        g = 0;
        if (exp_q.size() < D) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_rr + i) % N;
                if (!found && m_hv[c]) begin
                    found = 1'b1;
                    g = c;
                end
            end
        end
        if (m_log_tready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (found) begin
            exp_q.push_back(m_hd[g]);
            m_hv[g] = 1'b0;
            m_rr = (g + 1) % N;
        end
        for (int c = 0; c < N; c++) begin
            if (time_running && log_en[c] && (match[c*P +: P] != '0)) begin
                if (m_hv[c]) begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
                end else begin
                    m_hv[c] = 1'b1;
                    m_hd[c] = mk_entry(current_time, c, match[c*P +: P], match_ext_num[c*5 +: 5]);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_match(input int ch, input logic [P-1:0] mask, input logic [4:0] ext);
        match[ch*P +: P] = mask;
        match_ext_num[ch*5 +: 5] = ext;
    endtask

    task automatic clear_match();
        match = '0;
        match_ext_num = '0;
    endtask

    task automatic do_srst();
        clear_match();
        srst = 1'b1;
        step();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_log_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b want 0", m_log_tvalid); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        checks++; if (m_log_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %0h want 0", m_log_tdata); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        checks++; if (m_log_tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_tvalid: got %0b want 0", m_log_tvalid); end
    endtask

    task automatic test_single();
        do_srst();
        m_log_tready = 1'b0;
        current_time = 64'd1000;
        set_match(0, 4'b0010, 5'd3);
        step();
        clear_match();
        checks++; if (m_log_tvalid !== 1'b0) begin errors++; $display("FAIL single_t1_tvalid: got %0b want 0", m_log_tvalid); end
        step();
        checks++; if (m_log_tvalid !== 1'b1) begin errors++; $display("FAIL single_t2_tvalid: got %0b want 1", m_log_tvalid); end
        checks++; if (occupancy !== OCC_W'(1)) begin errors++; $display("FAIL single_occ: got %0d want 1", occupancy); end
        checks++; if (m_log_tdata !== mk_entry(64'd1000, 0, 4'b0010, 5'd3)) begin errors++; $display("FAIL single_tdata: got %0h want %0h", m_log_tdata, mk_entry(64'd1000, 0, 4'b0010, 5'd3)); end
        m_log_tready = 1'b1;
        step();
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL single_pop_occ: got %0d want 0", occupancy); end
        checks++; if (m_log_tvalid !== 1'b0) begin errors++; $display("FAIL single_pop_tvalid: got %0b want 0", m_log_tvalid); end
        m_log_tready = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_srst();
        m_log_tready = 1'b1;
        current_time = 64'd50;
        set_match(0, 4'b0001, 5'd1);
        set_match(1, 4'b1000, 5'd7);
        step();
        clear_match();
        step();
        checks++; if (m_log_tdata !== mk_entry(64'd50, 0, 4'b0001, 5'd1) || !m_log_tvalid) begin errors++; $display("FAIL simul_first: got %0h v=%0b want %0h", m_log_tdata, m_log_tvalid, mk_entry(64'd50, 0, 4'b0001, 5'd1)); end
        step();
        checks++; if (m_log_tdata !== mk_entry(64'd50, 1, 4'b1000, 5'd7) || !m_log_tvalid) begin errors++; $display("FAIL simul_second: got %0h v=%0b want %0h", m_log_tdata, m_log_tvalid, mk_entry(64'd50, 1, 4'b1000, 5'd7)); end
        step();
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL simul_drained: got %0d want 0", occupancy); end
        checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL simul_drop: got %0d want 0", drop_count); end
        m_log_tready = 1'b0;
    endtask

    task automatic test_fairness();
        int obs[$];
        do_srst();
        m_log_tready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            clear_match();
            current_time = 64'(200 + cyc);
            if (cyc < 8) begin
                set_match(1, 4'($urandom_range(1, 15)), 5'($urandom_range(0, 31)));
                if (cyc % 2 == 0) set_match(0, 4'($urandom_range(1, 15)), 5'($urandom_range(0, 31)));
            end
            step();
            checks++; if (m_log_tvalid !== (exp_q.size() != 0)) begin errors++; $display("FAIL fair_tvalid c%0d: got %0b want %0b", cyc, m_log_tvalid, exp_q.size() != 0); end
            checks++; if (drop_count !== m_drop) begin errors++; $display("FAIL fair_drop c%0d: got %0d want %0d", cyc, drop_count, m_drop); end
            if (exp_q.size() != 0) begin
                checks++; if (m_log_tdata !== exp_q[0]) begin errors++; $display("FAIL fair_tdata c%0d: got %0h want %0h", cyc, m_log_tdata, exp_q[0]); end
            end
            if (m_log_tvalid) obs.push_back(int'(m_log_tdata[P+5 +: IDX_W]));
        end
        checks++; if (obs.size() < 4) begin errors++; $display("FAIL fair_count: got %0d want >=4", obs.size()); end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            checks++; if (obs[i] != i % 2) begin errors++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, obs[i], i % 2); end
        end
        clear_match();
        m_log_tready = 1'b0;
    endtask

    task automatic test_overflow();
        do_srst();
        m_log_tready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            current_time = 64'(300 + 10 * k);
            set_match(0, 4'(k + 1), 5'(k));
            step();
            clear_match();
            step();
            step();
        end
        checks++; if (occupancy !== OCC_W'(4)) begin errors++; $display("FAIL ovf_occ: got %0d want 4", occupancy); end
        checks++; if (drop_count !== 32'd2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
        m_log_tready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            checks++; if (!m_log_tvalid || m_log_tdata[LOG_W-1 -: 64] !== 64'(300 + 10 * j)) begin errors++; $display("FAIL ovf_drain[%0d]: got ts %0d v=%0b want %0d", j, m_log_tdata[LOG_W-1 -: 64], m_log_tvalid, 300 + 10 * j); end
            step();
        end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL ovf_empty: got %0d want 0", occupancy); end
        m_log_tready = 1'b0;
    endtask

    task automatic test_enable_gating();
        do_srst();
        m_log_tready = 1'b0;
        log_en = 2'b01;
        current_time = 64'd77;
        set_match(0, 4'b0100, 5'd9);
        set_match(1, 4'b0001, 5'd2);
        step();
        clear_match();
        step();
        step();
        checks++; if (occupancy !== OCC_W'(1)) begin errors++; $display("FAIL gate_occ: got %0d want 1", occupancy); end
        checks++; if (m_log_tdata !== mk_entry(64'd77, 0, 4'b0100, 5'd9)) begin errors++; $display("FAIL gate_tdata: got %0h want %0h", m_log_tdata, mk_entry(64'd77, 0, 4'b0100, 5'd9)); end
        log_en = 2'b11;
        time_running = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_match(0, 4'b1111, 5'd1);
            set_match(1, 4'b1111, 5'd1);
            step();
        end
        clear_match();
        step();
        checks++; if (occupancy !== OCC_W'(1)) begin errors++; $display("FAIL stopped_occ: got %0d want 1", occupancy); end
        checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL stopped_drop: got %0d want 0", drop_count); end
        time_running = 1'b1;
    endtask

    task automatic fill_with_drops();
        m_log_tready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            current_time = 64'(500 + k);
            set_match(0, 4'b0011, 5'(k));
            step();
        end
        clear_match();
    endtask

    task automatic test_srst_mid_drain();
        do_srst();
        fill_with_drops();
        checks++; if (drop_count !== m_drop || m_drop == 0) begin errors++; $display("FAIL srst_pre_drop: got %0d want %0d", drop_count, m_drop); end
        m_log_tready = 1'b1;
        step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        checks++; if (m_log_tvalid !== 1'b0) begin errors++; $display("FAIL srst_tvalid: got %0b want 0", m_log_tvalid); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL srst_occ: got %0d want 0", occupancy); end
        checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL srst_drop: got %0d want 0", drop_count); end
        step();
        step();
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL srst_hold_clear: got %0d want 0", occupancy); end
        m_log_tready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_srst();
        fill_with_drops();
        m_log_tready = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_log_tvalid !== 1'b0) begin errors++; $display("FAIL arst_tvalid: got %0b want 0", m_log_tvalid); end
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL arst_occ: got %0d want 0", occupancy); end
        checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL arst_drop: got %0d want 0", drop_count); end
        #3;
        rst_n = 1'b1;
        model_reset();
        step();
        step();
        checks++; if (occupancy !== '0) begin errors++; $display("FAIL arst_hold_clear: got %0d want 0", occupancy); end
        m_log_tready = 1'b0;
    endtask

    task automatic test_random();
        do_srst();
        for (int cyc = 0; cyc < 400; cyc++) begin
            current_time = {32'($urandom), 32'($urandom)};
            log_en = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
            time_running = ($urandom_range(0, 9) != 0);
            m_log_tready = ($urandom_range(0, 1) == 1);
            clear_match();
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 2) == 0) set_match(c, 4'($urandom_range(1, 15)), 5'($urandom_range(0, 31)));
            end
            step();
            checks++; if (m_log_tvalid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_tvalid c%0d: got %0b want %0b", cyc, m_log_tvalid, exp_q.size() != 0); end
            checks++; if (occupancy !== OCC_W'(exp_q.size())) begin errors++; $display("FAIL rand_occ c%0d: got %0d want %0d", cyc, occupancy, exp_q.size()); end
            checks++; if (drop_count !== m_drop) begin errors++; $display("FAIL rand_drop c%0d: got %0d want %0d", cyc, drop_count, m_drop); end
            if (exp_q.size() != 0) begin
                checks++; if (m_log_tdata !== exp_q[0]) begin errors++; $display("FAIL rand_tdata c%0d: got %0h want %0h", cyc, m_log_tdata, exp_q[0]); end
            end
        end
        clear_match();
        log_en = 2'b11;
        time_running = 1'b1;
        m_log_tready = 1'b0;
    endtask

    initial begin
        log_en        = 2'b11;
        current_time  = '0;
        time_running  = 1'b1;
        match         = '0;
        match_ext_num = '0;
        m_log_tready  = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overflow();
        test_enable_gating();
        test_srst_mid_drain();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
